id_decode_stage: RTL and testbench
==================================

ID_DECODE_STAGE -- requirements
Module: id_decode_stage

Interface
REQ-001 Parameter PC_W, default 64, width of the PC carried with each instruction.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_flush  input  1  discard all held and in-flight instructions.
REQ-005 i_in_valid  input  1  upstream (fetch) instruction valid.
REQ-006 o_in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 i_instr  input  32  raw instruction word.
REQ-008 i_pc  input  PC_W  instruction PC.
REQ-009 o_out_valid  output  1  decoded entry valid toward execute.
REQ-010 i_out_ready  input  1  downstream accepts the entry.
REQ-011 o_instr  output  32  held instruction word.
REQ-012 o_pc  output  PC_W  held PC.
REQ-013 o_format  output  2  format code: R_FORM=00, I_FORM=01, BS_FORM=10, JU_FORM=11.
REQ-014 o_imm  output  64  sign-extended immediate.
REQ-015 o_illegal  output  1  opcode not recognised.

Function
REQ-016 Opcode i_instr[6:0] SHALL map: 0110011/0111011 -> R; 0010011/0011011/0000011/1100111/1110011 -> I; 0100011/1100011 -> BS; 0110111/0010111/1101111 -> JU; any other -> R with illegal=1.
REQ-017 Immediate SHALL be computed at accept time: I -> sign-extend i_instr[31:20]; BS -> sign-extend {i_instr[31:25],i_instr[11:7]}; R, JU, illegal -> 64'h0 (never X).
REQ-018 Format, immediate, illegal, instr and PC SHALL be captured together into one entry; no output is recomputed after capture.
REQ-019 Handshake: transfer in when i_in_valid && o_in_ready; transfer out when o_out_valid && i_out_ready.
REQ-020 Storage: main register (drives outputs) plus one skid register; FSM states EMPTY, FULL, SKID.
REQ-021 EMPTY: accept -> FULL (entry into main).
REQ-022 FULL: accept and no out-transfer -> SKID (entry into skid); out-transfer and no accept -> EMPTY; both -> FULL (new entry into main); neither -> FULL.
REQ-023 SKID: out-transfer -> FULL (skid entry moves to main, skid cleared); else SKID.
REQ-024 o_in_ready SHALL be 1 in EMPTY and FULL, 0 in SKID; it is derived from registered state only, with no combinational path from i_out_ready.
REQ-025 o_out_valid SHALL be 1 exactly in FULL and SKID.
REQ-026 Latency: an instruction accepted in EMPTY appears on outputs with o_out_valid=1 in the next cycle.
REQ-027 Order SHALL be preserved; no entry is dropped or duplicated absent flush.
REQ-028 While o_out_valid && !i_out_ready, all outputs SHALL hold stable.
REQ-029 Flush: next state EMPTY regardless of other inputs; an input accepted in the flush cycle is discarded; an out-transfer in the flush cycle still counts as completed.
REQ-030 Sustained throughput SHALL be one instruction per cycle when i_out_ready is held high.

Reset
REQ-031 i_rst asserted SHALL immediately force state EMPTY, o_out_valid=0, o_in_ready=0, o_instr=0, o_pc=0, o_format=00, o_imm=0, o_illegal=0.
REQ-032 o_in_ready SHALL rise to 1 on the first clock edge after i_rst deasserts; reset mid-operation discards all entries.

Verification
REQ-033 Accept 0xFFF00093 (addi x1,x0,-1) in EMPTY with i_out_ready=1 -> next cycle o_out_valid=1, o_format=01, o_imm=64'hFFFF_FFFF_FFFF_FFFF, o_illegal=0.
REQ-034 Accept 0x0020A423 (sw x2,8(x1)) then 0x002081B3 (add) -> o_format=10, o_imm=8, then o_format=00, o_imm=0, in order.
REQ-035 i_out_ready=0, feed three back-to-back instructions -> first two accepted (FULL, then SKID), o_in_ready=0 for the third, outputs frozen on the first; release i_out_ready -> all three emerge in order.
REQ-036 Accept 0x0000007F -> o_illegal=1, o_format=00, o_imm=0.
REQ-037 In SKID state, assert i_flush with i_in_valid=1 -> next cycle o_out_valid=0, o_in_ready=1, nothing emerges from the flushed entries.
REQ-038 Assert i_rst asynchronously mid-stream between edges -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/id_decode_stage.sv
// Instruction decode stage: classifies the incoming instruction word, builds its
// sign-extended immediate, and holds the result in a two-deep elastic buffer
// (main + skid) so that the upstream ready never depends combinationally on the
// downstream ready.
module id_decode_stage #(
  parameter int unsigned PC_W = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic [1:0]      o_format,
  output logic [63:0]     o_imm,
  output logic            o_illegal
);

  localparam logic [1:0] R_FORM  = 2'b00;
  localparam logic [1:0] I_FORM  = 2'b01;
  localparam logic [1:0] BS_FORM = 2'b10;
  localparam logic [1:0] JU_FORM = 2'b11;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [1:0]      fmt;
    logic [63:0]     imm;
    logic            illegal;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t dec;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   accept, drain;

  // Decode the incoming word into a complete entry, captured as-is on accept.
  always_comb begin
    dec.instr   = i_instr;
    dec.pc      = i_pc;
    dec.fmt     = R_FORM;
    dec.imm     = 64'h0;
    dec.illegal = 1'b0;
    unique case (i_instr[6:0])
      7'b0110011, 7'b0111011: dec.fmt = R_FORM;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = I_FORM;
        dec.imm = {{52{i_instr[31]}}, i_instr[31:20]};
      end
      7'b0100011, 7'b1100011: begin
        dec.fmt = BS_FORM;
        dec.imm = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      7'b0110111, 7'b0010111, 7'b1101111: dec.fmt = JU_FORM;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign accept = i_in_valid && in_ready_q;
  assign drain  = out_valid_q && i_out_ready;

  // Buffer next-state: where each entry lands, and the registered handshake flags.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          main_d  = dec;
        end
      end
      StFull: begin
        if (accept && !drain) begin
          state_d = StSkid;
          skid_d  = dec;
        end else if (drain && !accept) begin
          state_d = StEmpty;
          main_d  = '0;
        end else if (drain && accept) begin
          main_d  = dec;
        end
      end
      StSkid: begin
        if (drain) begin
          state_d = StFull;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = StEmpty;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
    // Flush wins over everything; a same-cycle drain has still completed downstream.
    if (i_flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end
    in_ready_d  = (state_d != StSkid);
    out_valid_d = (state_d != StEmpty);
  end

  // State and output registers; ready stays low during reset and rises on the first edge after.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_instr     = main_q.instr;
  assign o_pc        = main_q.pc;
  assign o_format    = main_q.fmt;
  assign o_imm       = main_q.imm;
  assign o_illegal   = main_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_decode_stage;

  localparam int unsigned PC_W = 64;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_flush = 1'b0;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [31:0]     i_instr = 32'h0;
  logic [PC_W-1:0] i_pc = '0;
  logic            o_out_valid;
  logic            i_out_ready = 1'b0;
  logic [31:0]     o_instr;
  logic [PC_W-1:0] o_pc;
  logic [1:0]      o_format;
  logic [63:0]     o_imm;
  logic            o_illegal;

  id_decode_stage #(.PC_W(PC_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_instr     (i_instr),
    .i_pc        (i_pc),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_format    (o_format),
    .o_imm       (o_imm),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two decoded entries.
  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [1:0]      fmt;
    logic [63:0]     imm;
    logic            ill;
  } ent_t;

  ent_t q[$];
  bit   rdy_ok = 1'b0;

  function automatic ent_t model_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    ent_t e;
    logic signed [11:0] s;
    logic [6:0] op;
    op = ins[6:0];
    e.instr = ins;
    e.pc = pc;
    e.fmt = 2'd0;
    e.imm = 64'd0;
    e.ill = 1'b0;
    if (op inside {7'h33, 7'h3B}) begin
      e.fmt = 2'd0;
    end else if (op inside {7'h13, 7'h1B, 7'h03, 7'h67, 7'h73}) begin
      e.fmt = 2'd1;
      s = ins[31:20];
      e.imm = 64'(s);
    end else if (op inside {7'h23, 7'h63}) begin
      e.fmt = 2'd2;
      s = {ins[31:25], ins[11:7]};
      e.imm = 64'(s);
    end else if (op inside {7'h37, 7'h17, 7'h6F}) begin
      e.fmt = 2'd3;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic bit m_ready();
    return rdy_ok && (q.size() < 2);
  endfunction

  always @(posedge i_rst) begin
    q.delete();
    rdy_ok = 1'b0;
  end

  always @(posedge i_clk) begin
    bit acc, pop;
    if (!i_rst) begin
      acc = i_in_valid && m_ready();
      pop = (q.size() > 0) && i_out_ready;
      if (i_flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(model_decode(i_instr, i_pc));
      end
      rdy_ok = 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (i_rst) begin
      check("rst_in_ready", 64'(o_in_ready), 64'd0);
      check("rst_out_valid", 64'(o_out_valid), 64'd0);
      check("rst_payload", {o_instr, o_imm[31:0] | o_pc[31:0]}, 64'd0);
    end else begin
      check("m_in_ready", 64'(o_in_ready), 64'(m_ready()));
      check("m_out_valid", 64'(o_out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        check("m_instr", 64'(o_instr), 64'(q[0].instr));
        check("m_pc", 64'(o_pc), 64'(q[0].pc));
        check("m_format", 64'(o_format), 64'(q[0].fmt));
        check("m_imm", o_imm, q[0].imm);
        check("m_illegal", 64'(o_illegal), 64'(q[0].ill));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc);
    i_in_valid = v;
    i_instr = ins;
    i_pc = pc;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 32'h0, '0);
    repeat (n) @(negedge i_clk);
  endtask

  logic [31:0] optab [8] = '{32'hFFF00093, 32'h0020A423, 32'h002081B3, 32'h0000007F,
                             32'h80000037, 32'hFE209EE3, 32'h8000006F, 32'h7FF0B103};

  initial begin
    // Reset values while reset is held
    #3;
    check("reset_out_valid", 64'(o_out_valid), 64'd0);
    check("reset_in_ready", 64'(o_in_ready), 64'd0);
    check("reset_imm", o_imm, 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check("ready_low_after_release", 64'(o_in_ready), 64'd0);
    @(posedge i_clk);
    #1 check("ready_first_edge", 64'(o_in_ready), 64'd1);
    @(negedge i_clk);

    // addi x1,x0,-1
    i_out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 64'h100);
    @(negedge i_clk);
    drive(1'b0, 32'h0, '0);
    check("addi_valid", 64'(o_out_valid), 64'd1);
    check("addi_format", 64'(o_format), 64'd1);
    check("addi_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_illegal", 64'(o_illegal), 64'd0);
    check("addi_pc", o_pc, 64'h100);
    @(negedge i_clk);

    // sw then add, back to back
    drive(1'b1, 32'h0020A423, 64'h200);
    @(negedge i_clk);
    check("sw_format", 64'(o_format), 64'd2);
    check("sw_imm", o_imm, 64'd8);
    drive(1'b1, 32'h002081B3, 64'h204);
    @(negedge i_clk);
    drive(1'b0, 32'h0, '0);
    check("add_valid", 64'(o_out_valid), 64'd1);
    check("add_format", 64'(o_format), 64'd0);
    check("add_imm", o_imm, 64'd0);
    check("add_pc", o_pc, 64'h204);
    @(negedge i_clk);

    // illegal opcode
    drive(1'b1, 32'h0000007F, 64'h300);
    @(negedge i_clk);
    drive(1'b0, 32'h0, '0);
    check("ill_illegal", 64'(o_illegal), 64'd1);
    check("ill_format", 64'(o_format), 64'd0);
    check("ill_imm", o_imm, 64'd0);
    @(negedge i_clk);

    // Backpressure: three back-to-back, only two fit
    i_out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 64'h400);
    @(negedge i_clk);
    check("bp_a_out", 64'(o_instr), 64'h00100093);
    drive(1'b1, 32'h0020A423, 64'h404);
    @(negedge i_clk);
    check("bp_skid_ready", 64'(o_in_ready), 64'd0);
    check("bp_frozen_a", 64'(o_instr), 64'h00100093);
    drive(1'b1, 32'h00000037, 64'h408);
    @(negedge i_clk);
    check("bp_still_a", 64'(o_instr), 64'h00100093);
    check("bp_still_imm", o_imm, 64'd1);
    i_out_ready = 1'b1;
    @(negedge i_clk);
    check("bp_b_out", 64'(o_instr), 64'h0020A423);
    @(negedge i_clk);
    drive(1'b0, 32'h0, '0);
    check("bp_c_out", 64'(o_instr), 64'h00000037);
    check("bp_c_format", 64'(o_format), 64'd3);
    @(negedge i_clk);
    check("bp_drained", 64'(o_out_valid), 64'd0);

    // Flush while in SKID with a valid input present
    i_out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 64'h500);
    @(negedge i_clk);
    drive(1'b1, 32'h002081B3, 64'h504);
    @(negedge i_clk);
    i_flush = 1'b1;
    drive(1'b1, 32'hFFF00093, 64'h508);
    @(negedge i_clk);
    i_flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    check("flush_valid", 64'(o_out_valid), 64'd0);
    check("flush_ready", 64'(o_in_ready), 64'd1);
    i_out_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check("flush_nothing", 64'(o_out_valid), 64'd0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, optab[k], 64'(32'h600 + 4 * k));
      @(negedge i_clk);
    end
    #2 i_rst = 1'b1;
    #1;
    check("async_valid", 64'(o_out_valid), 64'd0);
    check("async_ready", 64'(o_in_ready), 64'd0);
    check("async_instr", 64'(o_instr), 64'd0);
    check("async_fmt", 64'(o_format), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b0, 32'h0, '0);
    @(negedge i_clk);
    check("post_reset_ready", 64'(o_in_ready), 64'd1);
    check("post_reset_empty", 64'(o_out_valid), 64'd0);

    // Mixed traffic sweep, model checks every cycle
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 3) != 0), optab[$urandom_range(0, 7)] ^ {$urandom_range(0, 255), 24'h0},
            64'({$urandom, $urandom}));
      i_out_ready = 1'($urandom_range(0, 2) != 0);
      i_flush = 1'($urandom_range(0, 29) == 0);
      @(negedge i_clk);
    end
    i_flush = 1'b0;
    i_out_ready = 1'b1;
    idle_cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
